// File: rtl/miriscv_cu_pkg.sv
// Shared types for the miriscv pipeline controller: FSM states and shadow-slot layout.
package miriscv_cu_pkg;

  localparam int CU_SLOTS = 3;
  // Shadow rd width follows the GPR address width of miriscv_gpr_pkg (x0..x31).
  localparam int CU_RD_W  = 5;

  typedef enum logic [1:0] {
    CU_RUN   = 2'd0,
    CU_FLUSH = 2'd1,
    CU_FENCE = 2'd2
  } cu_state_e;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic [CU_RD_W-1:0] rd;
  } cu_slot_t;

endpackage

// File: rtl/miriscv_cu_scoreboard.sv
// Shadow destination slots mirroring the D, E and M pipeline registers, plus the
// RAW comparator used to interlock Decode (the core has no operand forwarding).
module miriscv_cu_scoreboard
  import miriscv_cu_pkg::*;
#(
  parameter int GPR_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  f_valid_i,
  input  logic [GPR_ADDR_W-1:0] rs1_addr_i,
  input  logic                  rs1_req_i,
  input  logic [GPR_ADDR_W-1:0] rs2_addr_i,
  input  logic                  rs2_req_i,
  input  logic [GPR_ADDR_W-1:0] rd_addr_i,
  input  logic                  wb_we_i,
  input  logic                  stall_f_i,
  input  logic                  stall_d_i,
  input  logic                  stall_e_i,
  input  logic                  stall_m_i,
  input  logic                  kill_d_i,
  output logic                  hazard_o,
  output logic                  busy_o
);

  // Index 0 = SD, 1 = SE, 2 = SM
  cu_slot_t [CU_SLOTS-1:0] slot_q;
  logic     [CU_SLOTS-1:0] hit1, hit2, vld;
  logic     [CU_RD_W-1:0]  rs1, rs2;

  assign rs1 = CU_RD_W'(rs1_addr_i);
  assign rs2 = CU_RD_W'(rs2_addr_i);

  for (genvar g = 0; g < CU_SLOTS; g++) begin : g_cmp
    assign vld[g]  = slot_q[g].valid;
    assign hit1[g] = slot_q[g].valid & slot_q[g].we & (slot_q[g].rd == rs1);
    assign hit2[g] = slot_q[g].valid & slot_q[g].we & (slot_q[g].rd == rs2);
  end

  // SM still counts in its writeback cycle: the GPR file is read-visible only next cycle.
  assign hazard_o = f_valid_i &
                    ((rs1_req_i & (rs1 != '0) & (|hit1)) |
                     (rs2_req_i & (rs2 != '0) & (|hit2)));
  assign busy_o   = |vld;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      slot_q <= '0;
    end else begin
      if (kill_d_i)
        slot_q[0] <= '0;
      else if (!stall_d_i)
        slot_q[0] <= '{valid: f_valid_i & ~stall_f_i, we: wb_we_i, rd: CU_RD_W'(rd_addr_i)};
      if (!stall_e_i)
        slot_q[1] <= '{valid: slot_q[0].valid & ~stall_d_i & ~kill_d_i,
                       we: slot_q[0].we, rd: slot_q[0].rd};
      if (!stall_m_i)
        slot_q[2] <= '{valid: slot_q[1].valid & ~stall_e_i,
                       we: slot_q[1].we, rd: slot_q[1].rd};
    end
  end

endmodule

// File: rtl/miriscv_pipeline_control.sv
// miriscv pipeline controller: stall priority, flush/fence FSM and PC redirect.
// Optional performance counters are built only with MIRISCV_PERF_CNT_EN defined.
module miriscv_pipeline_control
  import miriscv_cu_pkg::*;
#(
  parameter int GPR_ADDR_W = 5,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  f_valid_i,
  input  logic [GPR_ADDR_W-1:0] d_rs1_addr_i,
  input  logic [GPR_ADDR_W-1:0] d_rs2_addr_i,
  input  logic                  d_rs1_req_i,
  input  logic                  d_rs2_req_i,
  input  logic [GPR_ADDR_W-1:0] d_rd_addr_i,
  input  logic                  d_wb_we_i,
  input  logic                  d_fence_i,
  input  logic                  e_stall_req_i,
  input  logic                  m_stall_req_i,
  input  logic                  e_mispredict_i,
  output logic                  cu_stall_f_o,
  output logic                  cu_stall_d_o,
  output logic                  cu_stall_e_o,
  output logic                  cu_stall_m_o,
  output logic                  cu_kill_f_o,
  output logic                  cu_kill_d_o,
  output logic                  cu_redirect_o,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt_o,
  output logic [PERF_CNT_W-1:0] perf_flush_cnt_o
);

  cu_state_e state_q, state_d;
  logic stall_f, stall_d, stall_e, stall_m;
  logic kill_f, kill_d, redirect;
  logic hazard, busy, fence_wait, mp_take, fence_acc;

  assign stall_m    = m_stall_req_i;
  assign stall_e    = stall_m | e_stall_req_i;
  assign stall_d    = stall_e;
  assign fence_wait = (state_q == CU_FENCE) & busy;
  // Hazards and fence draining only hold Fetch, so D receives a bubble.
  assign stall_f    = stall_d | hazard | fence_wait;
  assign mp_take    = e_mispredict_i & ~stall_e & (state_q != CU_FLUSH);
  assign fence_acc  = f_valid_i & d_fence_i & ~stall_f & ~stall_d;

  miriscv_cu_scoreboard #(.GPR_ADDR_W(GPR_ADDR_W)) u_scoreboard (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .f_valid_i  (f_valid_i),
    .rs1_addr_i (d_rs1_addr_i),
    .rs1_req_i  (d_rs1_req_i),
    .rs2_addr_i (d_rs2_addr_i),
    .rs2_req_i  (d_rs2_req_i),
    .rd_addr_i  (d_rd_addr_i),
    .wb_we_i    (d_wb_we_i),
    .stall_f_i  (stall_f),
    .stall_d_i  (stall_d),
    .stall_e_i  (stall_e),
    .stall_m_i  (stall_m),
    .kill_d_i   (kill_d),
    .hazard_o   (hazard),
    .busy_o     (busy)
  );

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state_q <= CU_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    kill_f   = 1'b0;
    kill_d   = 1'b0;
    redirect = 1'b0;
    case (state_q)
      CU_RUN, CU_FENCE: begin
        if (mp_take) begin
          // Mispredict also kills a younger fence still draining.
          kill_f   = 1'b1;
          kill_d   = 1'b1;
          redirect = 1'b1;
          state_d  = CU_FLUSH;
        end else if (state_q == CU_RUN) begin
          if (fence_acc) state_d = CU_FENCE;
        end else if (!busy) begin
          state_d = fence_acc ? CU_FENCE : CU_RUN;
        end
      end
      CU_FLUSH: begin
        // Drop the fetch response that was already in flight at redirect time.
        kill_f  = 1'b1;
        state_d = CU_RUN;
      end
      default: state_d = CU_RUN;
    endcase
  end

  assign cu_stall_f_o  = stall_f;
  assign cu_stall_d_o  = stall_d;
  assign cu_stall_e_o  = stall_e;
  assign cu_stall_m_o  = stall_m;
  assign cu_kill_f_o   = kill_f;
  assign cu_kill_d_o   = kill_d;
  assign cu_redirect_o = redirect;

`ifdef MIRISCV_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f) stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
      if (mp_take) flush_cnt_q <= flush_cnt_q + PERF_CNT_W'(1);
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

endmodule
